// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions: operand-forwarding select codes, hazard FSM
// state encoding and the width of the hold-cycle down-counter.
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_e;

    localparam int REM_W = 2;

    // A pipeline stage can supply a source operand only if it really writes
    // the register file and the destination is not the hard-wired zero register.
    function automatic logic stage_hit(input logic we, input logic [7:0] dst, input logic [7:0] src);
        return we && (dst != 8'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Forwarding mux select for one ALU operand; MEM has priority over WB.
module fwd_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] exmemrd_i,
    input  logic          exmemregwrite_i,
    input  logic [AW-1:0] memwbrd_i,
    input  logic          memwbregwrite_i,
    output logic [1:0]    sel_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = stage_hit(exmemregwrite_i, 8'(exmemrd_i), 8'(src_i));
    assign wb_hit  = stage_hit(memwbregwrite_i, 8'(memwbrd_i), 8'(src_i));

    // Priority select: the younger MEM result overrides the older WB result.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use stall control with a saturating
// stall-cycle counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] idexrs,
    input  logic [AW-1:0] idexrt,
    input  logic [AW-1:0] ifidrs,
    input  logic [AW-1:0] ifidrt,
    input  logic [AW-1:0] idexrd,
    input  logic          idexmemread,
    input  logic [AW-1:0] exmemrd,
    input  logic          exmemregwrite,
    input  logic [AW-1:0] memwbrd,
    input  logic          memwbregwrite,
    output logic [1:0]    faout,
    output logic [1:0]    fbout,
    output logic          stall,
    output logic          bubble,
    output logic [CW-1:0] stallcnt
);

    hz_state_e        state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CW-1:0]    stallcnt_q, stallcnt_d;
    logic             stall_c;
    logic             detect;

    fwd_sel #(.AW(AW)) u_fwd_a (
        .src_i           (idexrs),
        .exmemrd_i       (exmemrd),
        .exmemregwrite_i (exmemregwrite),
        .memwbrd_i       (memwbrd),
        .memwbregwrite_i (memwbregwrite),
        .sel_o           (faout)
    );

    fwd_sel #(.AW(AW)) u_fwd_b (
        .src_i           (idexrt),
        .exmemrd_i       (exmemrd),
        .exmemregwrite_i (exmemregwrite),
        .memwbrd_i       (memwbrd),
        .memwbregwrite_i (memwbregwrite),
        .sel_o           (fbout)
    );

    // The load in EX targets a register the instruction in ID is about to read.
    assign detect = idexmemread && (idexrd != '0) &&
                    ((idexrd == ifidrs) || (idexrd == ifidrt));

    // Next-state and stall output; the detecting cycle itself is the first
    // stall cycle, HOLD covers the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    stall_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_HOLD;
                        rem_d   = REM_W'(LOAD_LAT - 2);
                    end
                end
            end
            ST_HOLD: begin
                stall_c = 1'b1;
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
        if (reset) begin
            stall_c = 1'b0;
        end
    end

    // Saturating count of cycles spent stalled.
    always_comb begin
        stallcnt_d = stallcnt_q;
        if (stall_c && (stallcnt_q != '1)) begin
            stallcnt_d = stallcnt_q + 1'b1;
        end
    end

    // State, hold counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            stallcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            stallcnt_q <= stallcnt_d;
        end
    end

    assign stall    = stall_c;
    assign bubble   = stall_c;
    assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: four hazard units with different LOAD_LAT/CW share the
// pipeline inputs; a reference model predicts every cycle's outputs.
module tb_hazard_forward_unit;

    localparam int N = 4;
    localparam int LL    [N] = '{1, 3, 4, 2};
    localparam int CWMAX [N] = '{7, 65535, 65535, 65535};

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [4:0] idexrs, idexrt, ifidrs, ifidrt, idexrd, exmemrd, memwbrd;
    logic       idexmemread, exmemregwrite, memwbregwrite;

    logic [1:0]  fa_o     [N];
    logic [1:0]  fb_o     [N];
    logic        stall_o  [N];
    logic        bubble_o [N];
    logic [15:0] cnt_o    [N];
    logic [2:0]  cnt_a;

    typedef struct packed {
        logic [1:0]        fa;
        logic [1:0]        fb;
        logic [3:0]        st;
        logic [3:0][15:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   busy [N];
    int   mcnt [N];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.AW(5), .LOAD_LAT(1), .CW(3)) u_a (
        .clk(clk), .reset(rst[0]), .idexrs(idexrs), .idexrt(idexrt), .ifidrs(ifidrs),
        .ifidrt(ifidrt), .idexrd(idexrd), .idexmemread(idexmemread), .exmemrd(exmemrd),
        .exmemregwrite(exmemregwrite), .memwbrd(memwbrd), .memwbregwrite(memwbregwrite),
        .faout(fa_o[0]), .fbout(fb_o[0]), .stall(stall_o[0]), .bubble(bubble_o[0]),
        .stallcnt(cnt_a));
    assign cnt_o[0] = 16'(cnt_a);

    hazard_forward_unit #(.AW(5), .LOAD_LAT(3), .CW(16)) u_b (
        .clk(clk), .reset(rst[1]), .idexrs(idexrs), .idexrt(idexrt), .ifidrs(ifidrs),
        .ifidrt(ifidrt), .idexrd(idexrd), .idexmemread(idexmemread), .exmemrd(exmemrd),
        .exmemregwrite(exmemregwrite), .memwbrd(memwbrd), .memwbregwrite(memwbregwrite),
        .faout(fa_o[1]), .fbout(fb_o[1]), .stall(stall_o[1]), .bubble(bubble_o[1]),
        .stallcnt(cnt_o[1]));

    hazard_forward_unit #(.AW(5), .LOAD_LAT(4), .CW(16)) u_c (
        .clk(clk), .reset(rst[2]), .idexrs(idexrs), .idexrt(idexrt), .ifidrs(ifidrs),
        .ifidrt(ifidrt), .idexrd(idexrd), .idexmemread(idexmemread), .exmemrd(exmemrd),
        .exmemregwrite(exmemregwrite), .memwbrd(memwbrd), .memwbregwrite(memwbregwrite),
        .faout(fa_o[2]), .fbout(fb_o[2]), .stall(stall_o[2]), .bubble(bubble_o[2]),
        .stallcnt(cnt_o[2]));

    hazard_forward_unit #(.AW(5), .LOAD_LAT(2), .CW(16)) u_d (
        .clk(clk), .reset(rst[3]), .idexrs(idexrs), .idexrt(idexrt), .ifidrs(ifidrs),
        .ifidrt(ifidrt), .idexrd(idexrd), .idexmemread(idexmemread), .exmemrd(exmemrd),
        .exmemregwrite(exmemregwrite), .memwbrd(memwbrd), .memwbregwrite(memwbregwrite),
        .faout(fa_o[3]), .fbout(fb_o[3]), .stall(stall_o[3]), .bubble(bubble_o[3]),
        .stallcnt(cnt_o[3]));

    // Forwarding rule: MEM result first, then WB, register 0 never forwarded.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (exmemregwrite && exmemrd != 0 && exmemrd == src) return 2'd2;
        if (memwbregwrite && memwbrd != 0 && memwbrd == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Predict this cycle's outputs from current inputs, queue them, then
    // advance the model across the coming clock edge.
    task automatic step();
        exp_t e;
        logic det;
        e.fa = ref_fwd(idexrs);
        e.fb = ref_fwd(idexrt);
        det  = idexmemread && idexrd != 0 && (idexrd == ifidrs || idexrd == ifidrt);
        for (int i = 0; i < N; i++) begin
            logic s;
            e.cnt[i] = 16'(mcnt[i]);
            if (rst[i]) begin
                s = 1'b0;
                busy[i] = 0;
                mcnt[i] = 0;
            end else begin
                if (busy[i] > 0) begin
                    s = 1'b1;
                    busy[i] = busy[i] - 1;
                end else if (det) begin
                    s = 1'b1;
                    busy[i] = LL[i] - 1;
                end else begin
                    s = 1'b0;
                end
                if (s && mcnt[i] < CWMAX[i]) mcnt[i] = mcnt[i] + 1;
            end
            e.st[i] = s;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        idexrs = 0; idexrt = 0; ifidrs = 0; ifidrt = 0; idexrd = 0; exmemrd = 0;
        memwbrd = 0; idexmemread = 0; exmemregwrite = 0; memwbregwrite = 0;
    endtask

    task automatic set_load(input logic on);
        idexmemread = on; idexrd = 5'd7; ifidrt = 5'd7; ifidrs = 5'd1;
    endtask

    // Monitor: sample mid-cycle, pop one prediction per cycle and compare.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("faout[%0d]", i), int'(fa_o[i]), int'(e.fa));
                    check($sformatf("fbout[%0d]", i), int'(fb_o[i]), int'(e.fb));
                    check($sformatf("stall[%0d]", i), int'(stall_o[i]), int'(e.st[i]));
                    check($sformatf("bubble[%0d]", i), int'(bubble_o[i]), int'(e.st[i]));
                    check($sformatf("stallcnt[%0d]", i), int'(cnt_o[i]), int'(e.cnt[i]));
                end
                $display("cyc t=%0t fa=%0d fb=%0d stall=%b cnt=%0d/%0d/%0d/%0d",
                         $time, fa_o[0], fb_o[0], {stall_o[3], stall_o[2], stall_o[1], stall_o[0]},
                         cnt_o[0], cnt_o[1], cnt_o[2], cnt_o[3]);
            end
        end
    end

    // Stimulus
    initial begin
        clear_inputs();
        rst = 4'hF;
        for (int i = 0; i < N; i++) begin busy[i] = 0; mcnt[i] = 0; end
        @(posedge clk);
        @(negedge clk);
        step();                              // reset state visible
        rst = 4'h0;

        // MEM beats WB on the same source
        idexrs = 3; exmemrd = 3; exmemregwrite = 1; memwbrd = 3; memwbregwrite = 1;
        step();
        // Register 0 never forwarded; regwrite=0 never forwarded
        clear_inputs(); idexrt = 0; exmemrd = 0; exmemregwrite = 1;
        step();
        idexrt = 5; exmemrd = 5; exmemregwrite = 0;
        step();
        // WB-only hit
        clear_inputs(); idexrs = 9; idexrt = 9; memwbrd = 9; memwbregwrite = 1;
        step();
        // Load into r0 never stalls
        clear_inputs(); idexmemread = 1; idexrd = 0; ifidrs = 0;
        step();

        // Single-cycle load-use detect
        clear_inputs(); set_load(1'b1); step();
        set_load(1'b0); repeat (5) step();

        // Detect held across the LOAD_LAT=3 window, then removed
        set_load(1'b1); repeat (3) step();
        set_load(1'b0); repeat (4) step();

        // Reset during the second HOLD cycle of the LOAD_LAT=4 unit
        set_load(1'b1); step();
        set_load(1'b0); step();
        rst[2] = 1'b1; step();
        rst[2] = 1'b0; repeat (4) step();

        // Back-to-back stalls drive the 3-bit counter into saturation
        rst = 4'hF; step();
        rst = 4'h0;
        set_load(1'b1); repeat (9) step();
        set_load(1'b0); repeat (4) step();

        // Randomized traffic with occasional per-unit resets
        repeat (400) begin
            idexrs = 5'($urandom_range(0, 3));
            idexrt = 5'($urandom_range(0, 3));
            ifidrs = 5'($urandom_range(0, 3));
            ifidrt = 5'($urandom_range(0, 3));
            idexrd = 5'($urandom_range(0, 3));
            exmemrd = 5'($urandom_range(0, 3));
            memwbrd = 5'($urandom_range(0, 3));
            idexmemread   = 1'($urandom_range(0, 1));
            exmemregwrite = 1'($urandom_range(0, 1));
            memwbregwrite = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) rst[i] = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 4'h0;
        clear_inputs();

        repeat (2) @(negedge clk);
        #5;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
